adder_selftest: RTL

On-chip self-test sequencer for the 4-bit adder datapath, sitting between the tt_um top-level I/O and the adder instance. On a start pulse it drives every (a, b, cin) operand combination into the adder, samples the 5-bit result after a programmable settle time, and compares it against an internal reference sum. It reports pass/fail, a saturating error count and the first failing vector. This makes the block the initiator/checker counterpart of the adder's operand-in/sum-out interface.

---
 rtl/adder_selftest.sv | 112 +++++++++++
 1 files changed

// File: rtl/adder_selftest.sv
// Self-test sequencer: sweeps all 512 (a, b, cin) vectors through an external 4-bit adder
// and checks each 5-bit result. Optional macro ADDER_SELFTEST_FIRST_FAIL_EN enables first_fail capture.
module adder_selftest #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    output logic       dut_cin,
    input  logic [3:0] dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [8:0] first_fail
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [8:0] vec;
    logic [3:0] settle_cnt;
    logic [4:0] expected;
    logic       mismatch;
    logic [7:0] err_next;

    // The reference is built from the operands actually presented to the adder.
    always_comb begin
        expected = {1'b0, dut_a} + {1'b0, dut_b} + {4'b0000, dut_cin};
        mismatch = (expected != {dut_cout, dut_sum});
        err_next = err_count;
        if (mismatch && (err_count != 8'hFF))
            err_next = err_count + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            dut_a      <= '0;
            dut_b      <= '0;
            dut_cin    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        vec       <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DRIVE: begin
                    dut_a      <= vec[3:0];
                    dut_b      <= vec[7:4];
                    dut_cin    <= vec[8];
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST)
                        state <= CHECK;
                    else
                        settle_cnt <= settle_cnt + 4'd1;
                end
                CHECK: begin
                    err_count <= err_next;
                    if (vec == 9'd511) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                    end else begin
                        vec   <= vec + 9'd1;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_SELFTEST_FIRST_FAIL_EN
    // err_count never wraps back to zero, so zero means no mismatch yet in this run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail <= '0;
        end else if (ena) begin
            if (((state == IDLE) || (state == DONE)) && start)
                first_fail <= '0;
            else if ((state == CHECK) && mismatch && (err_count == 8'd0))
                first_fail <= vec;
        end
    end
`else
    assign first_fail = 9'h000;
`endif

endmodule
